// File: rtl/phase_clock_gen.sv
// Multi-channel phase-shifted clock generator driven from i_cpu_ck.
// Each channel runs IDLE -> PHASE_WAIT -> RUN; new settings apply only on a falling edge.
module phase_clock_gen #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_cpu_ck,
    input  logic              i_cpu_rst_n,
    input  logic              i_cfg_wr,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_half,
    input  logic [CNT_W-1:0]  i_cfg_phase,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_sync,
    output logic [NUM_CH-1:0] o_ck_ps,
    output logic [NUM_CH-1:0] o_rise_pulse,
    output logic [NUM_CH-1:0] o_locked
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PHASE_WAIT = 2'd1,
        RUN        = 2'd2
    } state_e;

    logic [31:0]      ch_ext;
    logic             in_range;
    logic [CNT_W-1:0] half_in;

    assign ch_ext   = 32'(i_cfg_ch);
    assign in_range = ch_ext < 32'(NUM_CH);
    assign half_in  = (i_cfg_half == '0) ? CNT_W'(1) : i_cfg_half;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] ah_q, ah_d;
        logic [CNT_W-1:0] ap_q, ap_d;
        logic [CNT_W-1:0] ph_q, ph_d;
        logic [CNT_W-1:0] pp_q, pp_d;
        logic             pf_q, pf_d;
        logic             q_q, q_d;
        logic             rise_q, rise_d;
        logic             lock_q, lock_d;
        logic             en;
        logic             wr_hit;
        logic             restart;

        assign en     = i_ch_en[c];
        assign wr_hit = i_cfg_wr && in_range && (i_cfg_ch == CH_W'(c));

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            ah_d    = ah_q;
            ap_d    = ap_q;
            ph_d    = ph_q;
            pp_d    = pp_q;
            pf_d    = pf_q;
            q_d     = q_q;
            restart = 1'b0;

            if (en && i_sync) begin
                restart = 1'b1;
            end else begin
                case (st_q)
                    IDLE: begin
                        q_d   = 1'b0;
                        cnt_d = '0;
                        if (en) restart = 1'b1;
                    end
                    PHASE_WAIT: begin
                        q_d = 1'b0;
                        if (!en) begin
                            st_d  = IDLE;
                            cnt_d = '0;
                        end else if (cnt_q == ap_q) begin
                            q_d   = 1'b1;
                            cnt_d = '0;
                            st_d  = RUN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (cnt_q == ah_q - CNT_W'(1)) begin
                            cnt_d = '0;
                            q_d   = ~q_q;
                            // Falling edge is the only safe point to stop or retune
                            if (q_q) begin
                                if (!en) st_d = IDLE;
                                else if (pf_q) restart = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        q_d   = 1'b0;
                        cnt_d = '0;
                    end
                endcase
            end

            if (restart) begin
                if (pf_q) begin
                    ah_d = ph_q;
                    ap_d = pp_q;
                end
                pf_d  = 1'b0;
                cnt_d = '0;
                q_d   = 1'b0;
                st_d  = PHASE_WAIT;
            end

            // A write landing on an apply cycle stays pending for the next one
            if (wr_hit) begin
                ph_d = half_in;
                pp_d = i_cfg_phase;
                pf_d = 1'b1;
            end

            rise_d = q_d & ~q_q;
            lock_d = (st_d == RUN) && !pf_d;
        end

        always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
            if (!i_cpu_rst_n) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                ah_q   <= CNT_W'(1);
                ap_q   <= '0;
                ph_q   <= CNT_W'(1);
                pp_q   <= '0;
                pf_q   <= 1'b0;
                q_q    <= 1'b0;
                rise_q <= 1'b0;
                lock_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                ah_q   <= ah_d;
                ap_q   <= ap_d;
                ph_q   <= ph_d;
                pp_q   <= pp_d;
                pf_q   <= pf_d;
                q_q    <= q_d;
                rise_q <= rise_d;
                lock_q <= lock_d;
            end
        end

        assign o_ck_ps[c]      = q_q;
        assign o_rise_pulse[c] = rise_q;
        assign o_locked[c]     = lock_q;
    end

endmodule

// File: tb/tb_phase_clock_gen.sv
// Directed bench for phase_clock_gen; expected rise cycles are queued
// per channel and a negedge monitor retires them against o_rise_pulse.
module tb_phase_clock_gen;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  half;
    logic [CW-1:0]  phase;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] ck;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] lock;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int exp_rise [NCH][$];

    phase_clock_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .i_cpu_ck    (clk),
        .i_cpu_rst_n (rst_n),
        .i_cfg_wr    (wr),
        .i_cfg_ch    (ch),
        .i_cfg_half  (half),
        .i_cfg_phase (phase),
        .i_ch_en     (en),
        .i_sync      (sync),
        .o_ck_ps     (ck),
        .o_rise_pulse(rise),
        .o_locked    (lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int c = 0; c < NCH; c++) begin
                if (rise[c]) begin
                    int e;
                    tests++;
                    if (exp_rise[c].size() == 0) begin
                        fails++;
                        $display("FAIL rise_ch%0d: unexpected rise at cycle %0d, none expected",
                                 c, cyc);
                    end else begin
                        e = exp_rise[c].pop_front();
                        if (e != cyc) begin
                            fails++;
                            $display("FAIL rise_ch%0d: rise at cycle %0d, expected %0d",
                                     c, cyc, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int t);
        exp_rise[c].push_back(t);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic cfg(input int c, input int h, input int p);
        wr    = 1'b1;
        ch    = CHW'(c);
        half  = CW'(h);
        phase = CW'(p);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < NCH; c++) begin
            tests++;
            if (exp_rise[c].size() != 0) begin
                fails++;
                $display("FAIL missing_rise_ch%0d: %0d rises outstanding, expected 0",
                         c, exp_rise[c].size());
                exp_rise[c].delete();
            end
        end
    endtask

    task automatic do_reset();
        drain();
        #2;
        rst_n = 1'b0;
        en    = '0;
        sync  = 1'b0;
        wr    = 1'b0;
        #1;
        chk("rst_ck", 32'(ck), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_lock", 32'(lock), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int m;
        rst_n = 1'b0;
        wr    = 1'b0;
        ch    = '0;
        half  = '0;
        phase = '0;
        en    = '0;
        sync  = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_ck", 32'(ck), 0);
        chk("init_rise", 32'(rise), 0);
        chk("init_lock", 32'(lock), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-run at half=3, then stays idle with enable low
        cfg(0, 3, 0);
        k  = cyc;
        en = 3'b001;
        push(0, k + 2);
        wait_until(k + 3);
        chk("r_high_before_rst", 32'(ck[0]), 1);
        do_reset();
        repeat (10) @(negedge clk);
        chk("r_idle_ck", 32'(ck), 0);
        chk("r_idle_lock", 32'(lock), 0);

        // quarter-phase pair
        cfg(0, 2, 0);
        cfg(1, 2, 1);
        k  = cyc;
        en = 3'b011;
        push(0, k + 2); push(0, k + 6); push(0, k + 10);
        push(1, k + 3); push(1, k + 7); push(1, k + 11);
        wait_until(k + 2);
        chk("qp_ck_k2", 32'(ck[1:0]), 2'b01);
        wait_until(k + 3);
        chk("qp_ck_k3", 32'(ck[1:0]), 2'b11);
        wait_until(k + 4);
        chk("qp_ck_k4", 32'(ck[1:0]), 2'b10);
        chk("qp_lock", 32'(lock[1:0]), 2'b11);
        wait_until(k + 12);
        do_reset();

        // live reconfig mid-high
        cfg(0, 4, 0);
        k  = cyc;
        en = 3'b001;
        push(0, k + 2);  push(0, k + 10); push(0, k + 17);
        push(0, k + 19); push(0, k + 21); push(0, k + 23);
        wait_until(k + 11);
        chk("lr_lock_before", 32'(lock[0]), 1);
        cfg(0, 1, 2);
        chk("lr_lock_pending", 32'(lock[0]), 0);
        chk("lr_still_high", 32'(ck[0]), 1);
        wait_until(k + 13);
        chk("lr_high_k13", 32'(ck[0]), 1);
        wait_until(k + 14);
        chk("lr_fall", 32'(ck[0]), 0);
        wait_until(k + 16);
        chk("lr_low_k16", 32'(ck[0]), 0);
        chk("lr_lock_k16", 32'(lock[0]), 0);
        wait_until(k + 17);
        chk("lr_rise_ck", 32'(ck[0]), 1);
        chk("lr_lock_k17", 32'(lock[0]), 1);
        wait_until(k + 24);
        do_reset();

        // half=0 coerced to 1
        cfg(0, 0, 0);
        k  = cyc;
        en = 3'b001;
        push(0, k + 2); push(0, k + 4); push(0, k + 6); push(0, k + 8);
        wait_until(k + 3);
        chk("h0_low_k3", 32'(ck[0]), 0);
        wait_until(k + 9);
        do_reset();

        // out-of-range write ignored; ch2 runs on reset defaults
        cfg(0, 2, 0);
        cfg(1, 3, 1);
        cfg(3, 1, 5);
        k  = cyc;
        en = 3'b111;
        push(0, k + 2); push(0, k + 6); push(0, k + 10);
        push(1, k + 3); push(1, k + 9);
        for (int i = 1; i <= 6; i++) push(2, k + 2 * i);
        wait_until(k + 13);
        do_reset();

        // half=255 -> period 510
        cfg(0, 255, 0);
        k  = cyc;
        en = 3'b001;
        push(0, k + 2); push(0, k + 512);
        wait_until(k + 256);
        chk("h255_high_end", 32'(ck[0]), 1);
        wait_until(k + 257);
        chk("h255_fall", 32'(ck[0]), 0);
        wait_until(k + 513);
        do_reset();

        // disable mid-high: full high then idle, re-enable
        cfg(0, 5, 0);
        k  = cyc;
        en = 3'b001;
        push(0, k + 2);
        wait_until(k + 3);
        en = 3'b000;
        wait_until(k + 6);
        chk("dis_high_k6", 32'(ck[0]), 1);
        wait_until(k + 7);
        chk("dis_fall_k7", 32'(ck[0]), 0);
        chk("dis_lock_k7", 32'(lock[0]), 0);
        wait_until(k + 12);
        chk("dis_idle_ck", 32'(ck[0]), 0);
        m  = cyc;
        en = 3'b001;
        push(0, m + 2); push(0, m + 12);
        wait_until(m + 13);
        do_reset();

        // sync mid-period realigns both channels
        cfg(0, 4, 0);
        cfg(1, 4, 3);
        k  = cyc;
        en = 3'b011;
        push(0, k + 2); push(0, k + 8);  push(0, k + 16);
        push(1, k + 5); push(1, k + 11); push(1, k + 19);
        wait_until(k + 6);
        chk("sy_ch1_high", 32'(ck[1]), 1);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sy_ck_zero", 32'(ck[1:0]), 2'b00);
        chk("sy_lock_zero", 32'(lock[1:0]), 2'b00);
        wait_until(k + 8);
        chk("sy_ck_k8", 32'(ck[1:0]), 2'b01);
        wait_until(k + 20);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
